fp_sp_to_ieee_stream: RTL and testbench

Streaming converter from the FloPoCo single-precision format (34-bit: 2 exception bits, sign, 8-bit exponent, 23-bit fraction) to IEEE-754 binary32. It sits directly downstream of the U32-to-FP single-precision converters and feeds memory/AXI-side consumers that expect plain IEEE words. The datapath is a 2-stage registered pipeline with valid/ready flow control and a global clock enable. It also reports per-word conversion flags.

---
 rtl/fp_sp_to_ieee_stream_if.sv | 22 ++
 rtl/fp_sp_to_ieee_stream.sv | 151 +++++++++++++++
 tb/tb_fp_sp_to_ieee_stream.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fp_sp_to_ieee_stream_if.sv
// Stream bundle for fp_sp_to_ieee_stream: FloPoCo words in, IEEE binary32 words plus flags out.
// slave is the converter's view and master is the producer/consumer side.
interface fp_sp_to_ieee_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [33:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        flag_flush;
    logic        flag_ovf;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, flag_flush, flag_ovf
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, flag_flush, flag_ovf
    );
endinterface

// File: rtl/fp_sp_to_ieee_stream.sv
// Two-stage FloPoCo single-precision to IEEE-754 binary32 converter with valid/ready and clock enable.
// Define FP_SP_TO_IEEE_SUBNORMAL_EN to turn exponent-0 normals into IEEE subnormals instead of flushing.
module fp_sp_to_ieee_stream (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    fp_sp_to_ieee_stream_if.slave  io
);
    // Handshake: a word moves on a rising edge when valid && ready && ce on that side;
    // valid never waits on ready, and ready may depend combinationally on out_ready.
    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_INF  = 3'd2,
        CLS_NAN  = 3'd3,
        CLS_OVF  = 3'd4,
        CLS_SUB  = 3'd5
    } cls_e;

    logic        s1_valid_q, s1_valid_d;
    cls_e        s1_cls_q, s1_cls_d;
    logic        s1_sign_q, s1_sign_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [22:0] s1_frac_q, s1_frac_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic        s2_flush_q, s2_flush_d;
    logic        s2_ovf_q, s2_ovf_d;

    logic        s1_load, s2_load;
    cls_e        in_cls;
    logic [31:0] asm_data;
    logic        asm_flush, asm_ovf;
`ifdef FP_SP_TO_IEEE_SUBNORMAL_EN
    logic [23:0] sub_mant;
`endif

    always_comb begin
        s2_load = ce && (!s2_valid_q || io.out_ready);
        s1_load = ce && (!s1_valid_q || s2_load);
    end

    // Stage 1 decode: classify the incoming word by exception bits and exponent extremes.
    always_comb begin
        in_cls = CLS_ZERO;
        case (io.in_data[33:32])
            2'b00: in_cls = CLS_ZERO;
            2'b10: in_cls = CLS_INF;
            2'b11: in_cls = CLS_NAN;
            default: begin
                if (io.in_data[30:23] == 8'hFF)      in_cls = CLS_OVF;
                else if (io.in_data[30:23] == 8'h00) in_cls = CLS_SUB;
                else                                 in_cls = CLS_NORM;
            end
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_cls_d   = s1_cls_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_frac_d  = s1_frac_q;
        if (s1_load) begin
            s1_valid_d = io.in_valid;
            if (io.in_valid) begin
                s1_cls_d  = in_cls;
                s1_sign_d = io.in_data[31];
                s1_exp_d  = io.in_data[30:23];
                s1_frac_d = io.in_data[22:0];
            end
        end
    end

    // Stage 2 assembly from the registered class.
    always_comb begin
        asm_data  = {s1_sign_q, 31'h0};
        asm_flush = 1'b0;
        asm_ovf   = 1'b0;
`ifdef FP_SP_TO_IEEE_SUBNORMAL_EN
        // One bit is shifted out, so a set bit is always an exact tie: round up only onto an odd LSB.
        sub_mant = {1'b0, 1'b1, s1_frac_q[22:1]} + {23'd0, s1_frac_q[0] & s1_frac_q[1]};
`endif
        case (s1_cls_q)
            CLS_ZERO: asm_data = {s1_sign_q, 31'h0};
            CLS_INF:  asm_data = {s1_sign_q, 8'hFF, 23'h0};
            CLS_NAN:  asm_data = 32'h7FC00000;
            CLS_NORM: asm_data = {s1_sign_q, s1_exp_q, s1_frac_q};
            CLS_OVF: begin
                asm_data = {s1_sign_q, 8'hFF, 23'h0};
                asm_ovf  = 1'b1;
            end
            CLS_SUB: begin
`ifdef FP_SP_TO_IEEE_SUBNORMAL_EN
                asm_data = {s1_sign_q, 7'h0, sub_mant};
`else
                asm_data  = {s1_sign_q, 31'h0};
                asm_flush = 1'b1;
`endif
            end
            default: asm_data = {s1_sign_q, 31'h0};
        endcase
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_flush_d = s2_flush_q;
        s2_ovf_d   = s2_ovf_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_data_d  = asm_data;
                s2_flush_d = asm_flush;
                s2_ovf_d   = asm_ovf;
            end
        end
    end

    // Reset wins over ce so in-flight words are always discarded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s1_cls_q   <= CLS_ZERO;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= 8'h0;
            s1_frac_q  <= 23'h0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'h0;
            s2_flush_q <= 1'b0;
            s2_ovf_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_cls_q   <= s1_cls_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_frac_q  <= s1_frac_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_flush_q <= s2_flush_d;
            s2_ovf_q   <= s2_ovf_d;
        end
    end

    assign io.in_ready   = rst && s1_load;
    assign io.out_valid  = s2_valid_q;
    assign io.out_data   = s2_data_q;
    assign io.flag_flush = s2_flush_q;
    assign io.flag_ovf   = s2_ovf_q;
endmodule

// File: tb/tb_fp_sp_to_ieee_stream.sv
// Directed bench for fp_sp_to_ieee_stream: hand-computed vectors, scoreboard of {flush, ovf, data}.
// Build with FP_SP_TO_IEEE_SUBNORMAL_EN defined to exercise the subnormal vectors.
module tb_fp_sp_to_ieee_stream;
    logic clk = 1'b0;
    logic rst;
    logic ce;

    fp_sp_to_ieee_stream_if bus ();

    fp_sp_to_ieee_stream dut (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .io  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Expected entries are {flag_flush, flag_ovf, out_data}; age counts enabled edges since acceptance.
    logic [33:0] exp_q[$];
    int          age_q[$];

    task automatic check_eq(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check outputs against the model, then cross one rising edge.
    task automatic cyc(input logic v, input logic [33:0] d, input logic [33:0] e,
                       input logic ordy, output logic fired);
        logic exp_ov, exp_ir, out_fire;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
        exp_ov = (exp_q.size() > 0) && (age_q[0] >= 2);
        exp_ir = rst && ce && ((exp_q.size() < 2) || ordy);
        check_eq("out_valid", {33'd0, bus.out_valid}, {33'd0, exp_ov});
        if (exp_ov)
            check_eq("out_word", {bus.flag_flush, bus.flag_ovf, bus.out_data}, exp_q[0]);
        check_eq("in_ready", {33'd0, bus.in_ready}, {33'd0, exp_ir});
        out_fire = exp_ov && ordy && ce && rst;
        fired    = v && exp_ir;
        if (!rst) begin
            exp_q.delete();
            age_q.delete();
        end else begin
            if (out_fire) begin
                void'(exp_q.pop_front());
                void'(age_q.pop_front());
            end
            if (fired) begin
                exp_q.push_back(e);
                age_q.push_back(0);
            end
        end
        @(posedge clk);
        if (rst && ce)
            foreach (age_q[i]) age_q[i] = age_q[i] + 1;
        @(negedge clk);
    endtask

    task automatic send(input logic [33:0] d, input logic [33:0] e, input logic ordy);
        logic f;
        int   n;
        f = 1'b0;
        n = 0;
        while (!f && n < 50) begin
            cyc(1'b1, d, e, ordy, f);
            n++;
        end
        check_eq("send_accept", {33'd0, f}, 34'd1);
    endtask

    task automatic drain();
        logic f;
        int   n;
        n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            cyc(1'b0, 34'h0, 34'h0, 1'b1, f);
            n++;
        end
        check_eq("drain_empty", 34'(exp_q.size()), 34'd0);
        cyc(1'b0, 34'h0, 34'h0, 1'b1, f);
    endtask

    function automatic logic [33:0] bp_word(input int i);
        return {2'b01, 32'h3F800000 + 32'(i) * 32'h00012345};
    endfunction

    initial begin
        logic f;
        int   idx;
        int   n;
        logic ordy;

        rst = 1'b0;
        ce  = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 34'h0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset: in_ready must stay low even with a valid offered.
        cyc(1'b1, 34'h1_3F800000, 34'h0, 1'b1, f);
        rst = 1'b1;
        check_eq("rst_out_data", {2'b00, bus.out_data}, 34'h0);
        check_eq("rst_flags", {32'd0, bus.flag_flush, bus.flag_ovf}, 34'h0);

        // Basic conversion, back-to-back.
        cyc(1'b1, 34'h1_3F800000, {2'b00, 32'h3F800000}, 1'b1, f);
        cyc(1'b1, 34'h0_80000000, {2'b00, 32'h80000000}, 1'b1, f);
        drain();

        // Special values and exponent boundaries.
        send(34'h3_00000001, {2'b00, 32'h7FC00000}, 1'b1);
        send(34'h2_80000000, {2'b00, 32'hFF800000}, 1'b1);
        send(34'h1_7F800000, {2'b01, 32'h7F800000}, 1'b1);
        send(34'h3_FFFFFFFF, {2'b00, 32'h7FC00000}, 1'b1);
        send(34'h2_12345678, {2'b00, 32'h7F800000}, 1'b1);
        send(34'h0_3F812345, {2'b00, 32'h00000000}, 1'b1);
        send(34'h1_FF800001, {2'b01, 32'hFF800000}, 1'b1);
        send(34'h1_7F7FFFFF, {2'b00, 32'h7F7FFFFF}, 1'b1);
        send(34'h1_00800000, {2'b00, 32'h00800000}, 1'b1);
        send(34'h1_C0490FDB, {2'b00, 32'hC0490FDB}, 1'b1);
`ifdef FP_SP_TO_IEEE_SUBNORMAL_EN
        send(34'h1_00000000, {2'b00, 32'h00400000}, 1'b1);
        send(34'h1_00000003, {2'b00, 32'h00400002}, 1'b1);
        send(34'h1_007FFFFF, {2'b00, 32'h00800000}, 1'b1);
        send(34'h1_80000001, {2'b00, 32'h80400000}, 1'b1);
        send(34'h1_80000002, {2'b00, 32'h80400001}, 1'b1);
`else
        send(34'h1_80000000, {2'b10, 32'h80000000}, 1'b1);
        send(34'h1_00000003, {2'b10, 32'h00000000}, 1'b1);
        send(34'h1_007FFFFF, {2'b10, 32'h00000000}, 1'b1);
`endif
        drain();

        // Backpressure: fill both stages first, then random out_ready.
        idx = 0;
        n   = 0;
        while ((idx < 8 || exp_q.size() > 0) && n < 300) begin
            ordy = (n < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            if (idx < 8)
                cyc(1'b1, bp_word(idx), {2'b00, bp_word(idx)[31:0]}, ordy, f);
            else
                cyc(1'b0, 34'h0, 34'h0, ordy, f);
            if (f) idx++;
            n++;
        end
        check_eq("bp_all_sent", 34'(idx), 34'd8);
        check_eq("bp_drained", 34'(exp_q.size()), 34'd0);
        drain();

        // Clock enable low for 3 cycles mid-stream freezes everything.
        cyc(1'b1, 34'h1_40000000, {2'b00, 32'h40000000}, 1'b1, f);
        cyc(1'b1, 34'h1_C0800000, {2'b00, 32'hC0800000}, 1'b1, f);
        ce = 1'b0;
        repeat (3) cyc(1'b1, 34'h1_41200000, {2'b00, 32'h41200000}, 1'b1, f);
        ce = 1'b1;
        send(34'h1_41200000, {2'b00, 32'h41200000}, 1'b1);
        drain();

        // Reset with two words held discards them.
        send(34'h1_3F000000, {2'b00, 32'h3F000000}, 1'b0);
        send(34'h2_00000000, {2'b00, 32'h7F800000}, 1'b0);
        cyc(1'b0, 34'h0, 34'h0, 1'b0, f);
        rst = 1'b0;
        cyc(1'b1, 34'h1_3F800000, 34'h0, 1'b1, f);
        rst = 1'b1;
        check_eq("rst2_out_valid", {33'd0, bus.out_valid}, 34'd0);
        check_eq("rst2_out_data", {2'b00, bus.out_data}, 34'h0);
        send(34'h1_BF800000, {2'b00, 32'hBF800000}, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
